fb_lcd_capture: RTL
===================

FB_LCD_CAPTURE -- requirements
Module: fb_lcd_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 160, active pixels per line.
REQ-002 SHALL have parameter V_LINES, default 144, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-request buffer entries (power of 2, >=2).
REQ-004 SHALL have port fbclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port fbclk_rst_b  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pix_valid  input  1  pix_data carries one LCD pixel this cycle.
REQ-007 SHALL have port pix_data  input  2  Game Boy 2-bit shade.
REQ-008 SHALL have port pix_vs  input  1  one-cycle pulse; next accepted pixel is (line 0, col 0).
REQ-009 SHALL have port pix_hs  input  1  one-cycle pulse at end of line; next accepted pixel is col 0 of next line.
REQ-010 SHALL have port wr_valid  output  1  framebuffer write request pending.
REQ-011 SHALL have port wr_ready  input  1  framebuffer accepts request this cycle.
REQ-012 SHALL have port wr_addr  output  15  linear pixel address, line*H_PIXELS+col.
REQ-013 SHALL have port wr_data  output  2  pixel shade for wr_addr.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when last pixel of frame is written.
REQ-015 SHALL have port synced  output  1  high while state is ACTIVE.
REQ-016 SHALL have port overflow  output  1  sticky; pixel dropped due to full FIFO.

Function
REQ-017 SHALL implement states WAIT_VS and ACTIVE; WAIT_VS->ACTIVE on pix_vs; ACTIVE->WAIT_VS when pixel (V_LINES-1, H_PIXELS-1) is pushed.
REQ-018 SHALL discard pixels in WAIT_VS without pushing and without setting overflow.
REQ-019 SHALL, on pix_vs in either state, clear col, line, and line_base to 0 (restart mid-frame; FIFO contents retained).
REQ-020 SHALL, on pix_hs in ACTIVE, set col=0, line+=1, line_base+=H_PIXELS (no multiplier; address = line_base+col).
REQ-021 SHALL treat pix_vs or pix_hs coincident with pix_valid as taking effect first; that pixel lands at the new position.
REQ-022 SHALL push {address, pix_data} when pix_valid, ACTIVE, col<H_PIXELS, line<V_LINES; col increments after each push.
REQ-023 SHALL silently drop pixels with col>=H_PIXELS or line>=V_LINES (no overflow).
REQ-024 SHALL present FIFO head on wr_valid/wr_addr/wr_data from registers; pop on wr_valid & wr_ready.
REQ-025 SHALL yield latency of 1 cycle: pixel pushed at cycle N into empty FIFO gives wr_valid=1 at N+1.
REQ-026 SHALL hold wr_addr/wr_data stable while wr_valid & !wr_ready.
REQ-027 SHALL, when FIFO full and no pop, drop an eligible pixel, set overflow=1, and still advance col.
REQ-028 SHALL, when FIFO full with a pop in the same cycle, accept the push (no drop).
REQ-029 SHALL keep wr_valid=0 when FIFO empty; wr_addr/wr_data are don't-care then.
REQ-030 SHALL pulse frame_done exactly one cycle, the cycle after the handshake that pops address V_LINES*H_PIXELS-1.
REQ-031 SHALL keep pointers and count modulo FIFO_DEPTH with separate occupancy counter 0..FIFO_DEPTH.

Reset
REQ-032 SHALL, on fbclk_rst_b=0 at a rising edge, set state=WAIT_VS, col=line=line_base=0, FIFO empty.
REQ-033 SHALL drive wr_valid=0, frame_done=0, synced=0, overflow=0 after reset; overflow clears only by reset.
REQ-034 SHALL abandon in-flight FIFO entries on reset mid-frame, with no write issued after reset edge.

Verification
REQ-035 SHALL verify: reset, pix_vs, 1 pixel data=2, wr_ready=1 -> wr_valid at +1 cycle, wr_addr=0, wr_data=2.
REQ-036 SHALL verify: full 160x144 frame, wr_ready=1 -> 23040 writes, addresses 0..23039 in order, single frame_done after last, synced falls.
REQ-037 SHALL verify: wr_ready=0, 5 pixels with DEPTH=4 -> 4 entries held, overflow=1; wr_ready=1 -> addresses 0..3 then idle.
REQ-038 SHALL verify: 165 pixels then pix_hs -> addresses 0..159 only; next pixel addr 160; overflow stays 0.
REQ-039 SHALL verify: pixels before pix_vs dropped; pix_vs coincident with pix_valid mid-line -> that pixel writes addr 0.
REQ-040 SHALL verify: full FIFO with simultaneous push and pop -> no drop, overflow=0, occupancy stays 4.

Source files
------------

// File: rtl/fb_lcd_capture.sv
// Captures a Game Boy LCD pixel stream and turns it into linear framebuffer write requests.
// A small FIFO absorbs framebuffer back-pressure; pixels that do not fit are dropped.
module fb_lcd_capture #(
    parameter int unsigned H_PIXELS   = 160,
    parameter int unsigned V_LINES    = 144,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        fbclk,
    input  logic        fbclk_rst_b,
    input  logic        pix_valid,
    input  logic [1:0]  pix_data,
    input  logic        pix_vs,
    input  logic        pix_hs,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [14:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        frame_done,
    output logic        synced,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(H_PIXELS + 1);
    localparam int unsigned LW = $clog2(V_LINES + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] ColMax   = CW'(H_PIXELS);
    localparam logic [LW-1:0] LineMax  = LW'(V_LINES);
    localparam logic [14:0]   HStep    = 15'(H_PIXELS);
    localparam logic [14:0]   LastAddr = 15'(V_LINES * H_PIXELS - 1);
    localparam logic [NW-1:0] Full     = NW'(FIFO_DEPTH);

    typedef enum logic {StWaitVs, StActive} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_eff;
    logic [LW-1:0] line_q, line_d, line_eff;
    logic [14:0]   base_q, base_d, base_eff;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;
    logic          overflow_q, frame_done_q;
    logic [16:0]   mem_q [FIFO_DEPTH];

    logic          active_eff, eligible, push, pop, drop, last_px;
    logic [14:0]   addr_eff;

    // Sync pulses act before a coincident pixel, so position is resolved first.
    always_comb begin
        col_eff    = col_q;
        line_eff   = line_q;
        base_eff   = base_q;
        active_eff = (state_q == StActive);
        if (pix_vs) begin
            col_eff    = '0;
            line_eff   = '0;
            base_eff   = '0;
            active_eff = 1'b1;
        end else if (pix_hs && state_q == StActive) begin
            col_eff = '0;
            if (line_q < LineMax) begin
                line_eff = line_q + 1'b1;
                base_eff = base_q + HStep;
            end
        end
    end

    always_comb begin
        addr_eff = base_eff + 15'(col_eff);
        pop      = wr_valid && wr_ready;
        eligible = pix_valid && active_eff && (col_eff < ColMax) && (line_eff < LineMax);
        push     = eligible && ((count_q != Full) || pop);
        drop     = eligible && !push;
        last_px  = (col_eff == ColMax - 1'b1) && (line_eff == LineMax - 1'b1);

        col_d   = eligible ? col_eff + 1'b1 : col_eff;
        line_d  = line_eff;
        base_d  = base_eff;
        state_d = active_eff ? StActive : StWaitVs;
        if (push && last_px) begin
            state_d = StWaitVs;
        end
        count_d = count_q + NW'(push) - NW'(pop);
    end

    always_ff @(posedge fbclk) begin
        if (!fbclk_rst_b) begin
            state_q      <= StWaitVs;
            col_q        <= '0;
            line_q       <= '0;
            base_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            base_q       <= base_d;
            count_q      <= count_d;
            overflow_q   <= overflow_q | drop;
            frame_done_q <= pop && (wr_addr == LastAddr);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge fbclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {addr_eff, pix_data};
        end
    end

    assign wr_valid   = (count_q != '0);
    assign wr_addr    = mem_q[rd_ptr_q][16:2];
    assign wr_data    = mem_q[rd_ptr_q][1:0];
    assign frame_done = frame_done_q;
    assign synced     = (state_q == StActive);
    assign overflow   = overflow_q;

endmodule
